// File: rtl/phys_reg_alloc_ctrl.sv
// Dispatch-side physical register allocator: picks up to N free regs per cycle from the free-list
// bit-vector. Optional macro ALLOC_RR_EN enables a round-robin search pointer; otherwise the scan starts at reg 1.
module phys_reg_alloc_ctrl #(
  parameter  int N           = 3,
  parameter  int PHYS_REGS   = 64,
  parameter  int RECOVER_CYC = 2,
  localparam int PREG_W      = $clog2(PHYS_REGS),
  localparam int CNT_W       = $clog2(N + 1),
  localparam int FC_W        = $clog2(PHYS_REGS + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PHYS_REGS-1:0]         free_list,
  input  logic                         restore_flag,
  input  logic [CNT_W-1:0]             dispatch_req,
  output logic [N-1:0]                 alloc_valid,
  output logic [N-1:0][PREG_W-1:0]     alloc_regs,
  output logic [CNT_W-1:0]             alloc_count,
  output logic [PHYS_REGS-1:0]         updated_free_list,
  output logic [FC_W-1:0]              free_count,
  output logic                         stall
);

  localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [REC_W-1:0] REC_LOAD = REC_W'(RECOVER_CYC - 1);

  typedef enum logic [1:0] {
    ST_WARM    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                 state_q;
  logic [REC_W-1:0]       rec_cnt_q;
  logic [CNT_W-1:0]       req_eff_s;
  logic                   grant_en_s;
  logic [PREG_W-1:0]      scan_base_s;
  logic [PREG_W:0]        pos_s;
  logic [PREG_W-1:0]      idx_s;
  logic [CNT_W-1:0]       taken_s;
  logic [PHYS_REGS-1:0]   grant_mask_s;
  logic [FC_W-1:0]        fc_d;

  // Count of free regs, reg 0 excluded since it is never allocatable.
  function automatic logic [FC_W-1:0] popcnt_no0(input logic [PHYS_REGS-1:0] v);
    logic [FC_W-1:0] c;
    c = '0;
    for (int i = 1; i < PHYS_REGS; i++) begin
      c = c + FC_W'(v[i]);
    end
    return c;
  endfunction

  assign req_eff_s  = (dispatch_req > CNT_W'(N)) ? CNT_W'(N) : dispatch_req;
  assign grant_en_s = reset && (state_q == ST_RUN) && !restore_flag;

`ifdef ALLOC_RR_EN
  logic [PREG_W-1:0] ptr_q;
  logic [PREG_W-1:0] ptr_d;
  logic [PREG_W-1:0] last_idx_s;
  assign scan_base_s = ptr_q;
`else
  assign scan_base_s = PREG_W'(1);
`endif

  // Scan regs 1..PHYS_REGS-1 starting at scan_base_s, filling slots in scan order.
  always_comb begin
    alloc_valid  = '0;
    alloc_regs   = '0;
    grant_mask_s = '0;
    taken_s      = '0;
    pos_s        = '0;
    idx_s        = '0;
`ifdef ALLOC_RR_EN
    last_idx_s   = '0;
`endif
    for (int off = 0; off < PHYS_REGS - 1; off++) begin
      pos_s = {1'b0, scan_base_s - PREG_W'(1)} + (PREG_W+1)'(off);
      if (pos_s >= (PREG_W+1)'(PHYS_REGS - 1)) begin
        pos_s = pos_s - (PREG_W+1)'(PHYS_REGS - 1);
      end else begin
        pos_s = pos_s;
      end
      idx_s = pos_s[PREG_W-1:0] + PREG_W'(1);
      if (grant_en_s && free_list[idx_s] && (taken_s < req_eff_s)) begin
        alloc_valid[taken_s] = 1'b1;
        alloc_regs[taken_s]  = idx_s;
        grant_mask_s[idx_s]  = 1'b1;
`ifdef ALLOC_RR_EN
        last_idx_s           = idx_s;
`endif
        taken_s              = taken_s + CNT_W'(1);
      end else begin
        taken_s = taken_s;
      end
    end
  end

  assign alloc_count       = taken_s;
  assign updated_free_list = free_list & ~grant_mask_s;
  assign stall             = (req_eff_s > taken_s);
  assign fc_d              = popcnt_no0(updated_free_list);

`ifdef ALLOC_RR_EN
  // Next search start: one past the last granted reg, wrapping past reg 0.
  always_comb begin
    if (taken_s != CNT_W'(0)) begin
      if (last_idx_s == PREG_W'(PHYS_REGS - 1)) begin
        ptr_d = PREG_W'(1);
      end else begin
        ptr_d = last_idx_s + PREG_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer; survives mispredict recovery, only reset reinitialises it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= PREG_W'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Control FSM plus registered free-count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_WARM;
      rec_cnt_q  <= '0;
      free_count <= '0;
    end else begin
      free_count <= fc_d;
      case (state_q)
        ST_WARM: begin
          if (restore_flag) begin
            state_q   <= ST_RECOVER;
            rec_cnt_q <= REC_LOAD;
          end else begin
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (restore_flag) begin
            state_q   <= ST_RECOVER;
            rec_cnt_q <= REC_LOAD;
          end else begin
            state_q   <= ST_RUN;
          end
        end
        ST_RECOVER: begin
          if (restore_flag) begin
            rec_cnt_q <= REC_LOAD;
          end else if (rec_cnt_q == REC_W'(0)) begin
            state_q   <= ST_RUN;
          end else begin
            rec_cnt_q <= rec_cnt_q - REC_W'(1);
          end
        end
        default: begin
          state_q   <= ST_WARM;
          rec_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phys_reg_alloc_ctrl.sv
// Table-driven directed bench for phys_reg_alloc_ctrl (default 3-wide, 64 regs, RECOVER_CYC=2).
module tb_phys_reg_alloc_ctrl;

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic        rst;
    logic        rest;
    logic [1:0]  req;
    logic [63:0] fl;
    logic [2:0]  valid;
    logic [5:0]  r0;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic        stall;
    logic        chk_fc;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [63:0]      free_list;
  logic             restore_flag;
  logic [1:0]       dispatch_req;
  logic [2:0]       alloc_valid;
  logic [2:0][5:0]  alloc_regs;
  logic [1:0]       alloc_count;
  logic [63:0]      updated_free_list;
  logic [6:0]       free_count;
  logic             stall;

  int n_checks;
  int n_fail;
  int fc_model;

  phys_reg_alloc_ctrl dut (
    .clock             (clk),
    .reset             (reset),
    .free_list         (free_list),
    .restore_flag      (restore_flag),
    .dispatch_req      (dispatch_req),
    .alloc_valid       (alloc_valid),
    .alloc_regs        (alloc_regs),
    .alloc_count       (alloc_count),
    .updated_free_list (updated_free_list),
    .free_count        (free_count),
    .stall             (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic rest, input logic [1:0] req,
                              input logic [63:0] fl, input logic [2:0] valid,
                              input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                              input logic st, input logic chk_fc);
    vec_t v;
    v.rst = rst; v.rest = rest; v.req = req; v.fl = fl; v.valid = valid;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.stall = st; v.chk_fc = chk_fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [63:0]     upd;
    logic [1:0]      cnt;
    logic [2:0][5:0] regs;
    @(negedge clk);
    reset        = v.rst;
    restore_flag = v.rest;
    dispatch_req = v.req;
    free_list    = v.fl;
    #1;
    regs = {v.r2, v.r1, v.r0};
    cnt  = 2'(v.valid[0]) + 2'(v.valid[1]) + 2'(v.valid[2]);
    upd  = v.fl;
    for (int s = 0; s < 3; s++) begin
      if (v.valid[s]) upd[regs[s]] = 1'b0;
    end
    check({tag, " valid"}, 64'(alloc_valid), 64'(v.valid));
    check({tag, " regs"},  64'(alloc_regs),  64'(regs));
    check({tag, " count"}, 64'(alloc_count), 64'(cnt));
    check({tag, " upd"},   updated_free_list, upd);
    check({tag, " stall"}, 64'(stall), 64'(v.stall));
    if (v.chk_fc) check({tag, " free_count"}, 64'(free_count), 64'(fc_model));
    fc_model = v.rst ? $countones(upd[63:1]) : 0;
  endtask

  vec_t vt[14];

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    fc_model     = 0;
    reset        = 1'b0;
    restore_flag = 1'b0;
    dispatch_req = 2'd0;
    free_list    = 64'd0;

    vt[0]  = mk(1'b0, 1'b0, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    vt[1]  = mk(1'b0, 1'b0, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1);
    vt[2]  = mk(1'b1, 1'b0, 2'd2, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1);
    vt[3]  = mk(1'b1, 1'b0, 2'd3, ALL, 3'b111, 6'd1, 6'd2, 6'd3, 1'b0, 1'b1);
`ifdef ALLOC_RR_EN
    vt[4]  = mk(1'b1, 1'b0, 2'd2, ALL, 3'b011, 6'd4, 6'd5, 6'd0, 1'b0, 1'b1);
    vt[5]  = mk(1'b1, 1'b0, 2'd3, 64'h0000_0000_0000_0220, 3'b011, 6'd9, 6'd5, 6'd0, 1'b1, 1'b1);
`else
    vt[4]  = mk(1'b1, 1'b0, 2'd2, ALL, 3'b011, 6'd1, 6'd2, 6'd0, 1'b0, 1'b1);
    vt[5]  = mk(1'b1, 1'b0, 2'd3, 64'h0000_0000_0000_0220, 3'b011, 6'd5, 6'd9, 6'd0, 1'b1, 1'b1);
`endif
    vt[6]  = mk(1'b1, 1'b0, 2'd0, 64'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1);
    vt[7]  = mk(1'b1, 1'b0, 2'd1, 64'd1, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1);
    vt[8]  = mk(1'b1, 1'b0, 2'd0, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1);
    vt[9]  = mk(1'b1, 1'b0, 2'd1, 64'h2000_0000_0000_0000, 3'b001, 6'd61, 6'd0, 6'd0, 1'b0, 1'b1);
`ifdef ALLOC_RR_EN
    vt[10] = mk(1'b1, 1'b0, 2'd3, 64'h8000_0000_0000_0006, 3'b111, 6'd63, 6'd1, 6'd2, 1'b0, 1'b1);
    vt[11] = mk(1'b1, 1'b0, 2'd1, ALL, 3'b001, 6'd3, 6'd0, 6'd0, 1'b0, 1'b1);
    vt[12] = mk(1'b1, 1'b0, 2'd3, 64'h0000_0100_4010_0400, 3'b111, 6'd10, 6'd20, 6'd30, 1'b0, 1'b1);
    vt[13] = mk(1'b1, 1'b0, 2'd3, 64'h0000_0100_4010_0400, 3'b111, 6'd40, 6'd10, 6'd20, 1'b0, 1'b1);
`else
    vt[10] = mk(1'b1, 1'b0, 2'd3, 64'h8000_0000_0000_0006, 3'b111, 6'd1, 6'd2, 6'd63, 1'b0, 1'b1);
    vt[11] = mk(1'b1, 1'b0, 2'd1, ALL, 3'b001, 6'd1, 6'd0, 6'd0, 1'b0, 1'b1);
    vt[12] = mk(1'b1, 1'b0, 2'd3, 64'h0000_0100_4010_0400, 3'b111, 6'd10, 6'd20, 6'd30, 1'b0, 1'b1);
    vt[13] = mk(1'b1, 1'b0, 2'd3, 64'h0000_0100_4010_0400, 3'b111, 6'd10, 6'd20, 6'd30, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Mispredict: restore cycle, RECOVER_CYC blocked cycles, then grants resume.
    run_vec(mk(1'b1, 1'b1, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1), "restore");
    run_vec(mk(1'b1, 1'b0, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1), "recover1");
    run_vec(mk(1'b1, 1'b0, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1), "recover2");
`ifdef ALLOC_RR_EN
    run_vec(mk(1'b1, 1'b0, 2'd3, ALL, 3'b111, 6'd21, 6'd22, 6'd23, 1'b0, 1'b1), "resume");
`else
    run_vec(mk(1'b1, 1'b0, 2'd3, ALL, 3'b111, 6'd1, 6'd2, 6'd3, 1'b0, 1'b1), "resume");
`endif

    // Reset while in RECOVER: WARM for one cycle, then allocation from reg 1.
    run_vec(mk(1'b1, 1'b1, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1), "restore2");
    run_vec(mk(1'b0, 1'b0, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1), "rst_in_rec");
    run_vec(mk(1'b1, 1'b0, 2'd3, ALL, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1), "warm2");
    run_vec(mk(1'b1, 1'b0, 2'd3, ALL, 3'b111, 6'd1, 6'd2, 6'd3, 1'b0, 1'b1), "post_rst");
    run_vec(mk(1'b1, 1'b0, 2'd0, 64'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1), "fc_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
